pool_layer_scheduler: RTL

Sequences the S4 max-pooling engine across all feature maps of one layer pass.
- For each map: drives the engine's cal_en window and base_position (output-buffer base address), waits for pool_done, then forces a quiet gap so the engine's internal counters clear before the next map.
- Sits between the layer-level controller (start/layer_done) and the pooling engine.
- Includes a per-map watchdog and an abort path.

---
 rtl/pool_layer_scheduler.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/pool_layer_scheduler.sv
// rtl/pool_layer_scheduler.sv - sequences the max-pooling engine across the feature maps of one layer pass
// Each map gets a quiet ARM gap, a cal_en window bounded by a watchdog, and a base-address step.
module pool_layer_scheduler #(
    parameter int NUM_MAPS    = 16,
    parameter int MAP_SIZE    = 25,
    parameter int BASE_OFFSET = 0,
    parameter int GAP_CYCLES  = 8,
    parameter int TIMEOUT     = 1023
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    input  logic        i_pool_done,
    output logic        o_cal_en,
    output logic [11:0] o_base_position,
    output logic [3:0]  o_map_idx,
    output logic        o_busy,
    output logic        o_layer_done,
    output logic        o_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    localparam int              GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [9:0]      TMO_LAST  = 10'(TIMEOUT - 1);
    localparam logic [3:0]      LAST_MAP  = 4'(NUM_MAPS - 1);
    localparam logic [11:0]     BASE_INIT = 12'(BASE_OFFSET);
    localparam logic [11:0]     MAP_STEP  = 12'(MAP_SIZE);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [9:0]       r_tmo_cnt;
    logic             r_cal_en;
    logic [11:0]      r_base;
    logic [3:0]       r_map_idx;
    logic             r_busy;
    logic             r_layer_done;
    logic             r_error;

    logic w_gap_ok;
    logic w_tmo_hit;
    logic w_last_map;

    // A stale pool_done from the previous map keeps us in ARM even after the gap elapses.
    assign w_gap_ok   = (r_gap_cnt >= GAP_LAST) && !i_pool_done;
    assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);
    assign w_last_map = (r_map_idx == LAST_MAP);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = S_ARM;
            S_ARM: begin
                if (i_abort)       w_state_nxt = S_IDLE;
                else if (w_gap_ok) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (i_abort)          w_state_nxt = S_IDLE;
                else if (i_pool_done) w_state_nxt = S_NEXT;
                else if (w_tmo_hit)   w_state_nxt = S_ERR;
            end
            S_NEXT: begin
                if (i_abort)         w_state_nxt = S_IDLE;
                else if (w_last_map) w_state_nxt = S_DONE;
                else                 w_state_nxt = S_ARM;
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_gap_cnt    <= '0;
            r_tmo_cnt    <= '0;
            r_cal_en     <= 1'b0;
            r_base       <= '0;
            r_map_idx    <= '0;
            r_busy       <= 1'b0;
            r_layer_done <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_layer_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_map_idx <= '0;
                        r_base    <= BASE_INIT;
                        r_busy    <= 1'b1;
                        r_error   <= 1'b0;
                        r_gap_cnt <= '0;
                    end
                end
                S_ARM: begin
                    if (i_abort) begin
                        r_busy <= 1'b0;
                    end else if (w_gap_ok) begin
                        r_cal_en  <= 1'b1;
                        r_tmo_cnt <= '0;
                    end else if (r_gap_cnt < GAP_LAST) begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (i_abort) begin
                        r_cal_en <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (i_pool_done) begin
                        r_cal_en <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_cal_en <= 1'b0;
                        r_error  <= 1'b1;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (i_abort) begin
                        r_busy <= 1'b0;
                    end else if (w_last_map) begin
                        r_layer_done <= 1'b1;
                    end else begin
                        r_map_idx <= r_map_idx + 1'b1;
                        r_base    <= r_base + MAP_STEP;
                        r_gap_cnt <= '0;
                    end
                end
                S_DONE: r_busy <= 1'b0;
                S_ERR: begin
                    r_busy   <= 1'b0;
                    r_cal_en <= 1'b0;
                end
                default: begin
                    r_busy   <= 1'b0;
                    r_cal_en <= 1'b0;
                end
            endcase
        end
    end

    assign o_cal_en        = r_cal_en;
    assign o_base_position = r_base;
    assign o_map_idx       = r_map_idx;
    assign o_busy          = r_busy;
    assign o_layer_done    = r_layer_done;
    assign o_error         = r_error;

endmodule
